// File: rtl/uart_pkg.sv
// uart_pkg: state encodings and default parameters shared by the UART transmitter and receiver.
package uart_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } uart_state_e;
   localparam int DEF_LENGTH     = 8;
   localparam int DEF_BIT_CYCLES = 1;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts 0..bit_cycles-1 while enabled, ticking on the terminal count and wrapping.
module uart_bit_timer #(
   parameter int bit_cycles = 1
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int TW = (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
   logic [TW-1:0] cnt_q, cnt_d;
   always_comb begin
      tick  = enable && (cnt_q == TW'(bit_cycles - 1));
      cnt_d = (clear || tick) ? '0 : enable ? cnt_q + TW'(1) : cnt_q;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: MSB-first serial transmitter with a LOAD strobe cycle before the data bits and a done pulse after.
module uart_tx
   import uart_pkg::*;
#(
   parameter int length     = DEF_LENGTH,
   parameter int bit_cycles = DEF_BIT_CYCLES
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [length-1:0] data_transmit_register,
   input  logic              send,
   output logic              ready,
   output logic              data_transmitter,
   output logic              shiftout,
   output logic              data_sent_signal,
   output logic [1:0]        current_state
);
   localparam int BW = $clog2(length + 1);
   uart_state_e       state_q, state_d;
   logic [length-1:0] sr_q, sr_d;
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic              ready_q, ready_d;
   logic              tx_q, tx_d;
   logic              shiftout_q, shiftout_d;
   logic              sent_q, sent_d;
   logic              tick;
   uart_bit_timer #(.bit_cycles(bit_cycles)) u_timer (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (state_q != SHIFT),
      .enable (state_q == SHIFT),
      .tick   (tick)
   );
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bcnt_d  = bcnt_q;
      unique case (state_q)
         IDLE: if (send) begin
            sr_d    = data_transmit_register;
            bcnt_d  = '0;
            state_d = LOAD;
         end
         LOAD: state_d = SHIFT;
         SHIFT: if (tick) begin
            sr_d    = {sr_q[length-2:0], 1'b0};
            bcnt_d  = bcnt_q + BW'(1);
            state_d = (bcnt_q == BW'(length - 1)) ? DONE : SHIFT;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Outputs are decoded from the next state so they are registered yet aligned with it.
      ready_d    = state_d == IDLE;
      shiftout_d = state_d == LOAD;
      tx_d       = (state_d == SHIFT) && sr_d[length-1];
      sent_d     = state_d == DONE;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state_q    <= IDLE;
         sr_q       <= '0;
         bcnt_q     <= '0;
         ready_q    <= 1'b1;
         tx_q       <= 1'b0;
         shiftout_q <= 1'b0;
         sent_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sr_q       <= sr_d;
         bcnt_q     <= bcnt_d;
         ready_q    <= ready_d;
         tx_q       <= tx_d;
         shiftout_q <= shiftout_d;
         sent_q     <= sent_d;
      end
   assign ready            = ready_q;
   assign data_transmitter = tx_q;
   assign shiftout         = shiftout_q;
   assign data_sent_signal = sent_q;
   assign current_state    = state_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed vectors for uart_tx with default timing and with bit_cycles=4.
module tb_uart_tx;
   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] data = 8'h00;
   logic       send0 = 1'b0, send1 = 1'b0;
   logic       rdy0, tx0, sh0, sent0, rdy1, tx1, sh1, sent1;
   logic [1:0] st0, st1;
   int         compared = 0, mismatched = 0, pulses0 = 0;
   localparam logic [5:0] E_IDLE = 6'b100000;
   localparam logic [5:0] E_LOAD = 6'b001001;
   localparam logic [5:0] E_DONE = 6'b000111;

   always #5 clk = ~clk;

   uart_tx dut0 (
      .clk(clk), .rstn(rstn), .data_transmit_register(data), .send(send0),
      .ready(rdy0), .data_transmitter(tx0), .shiftout(sh0),
      .data_sent_signal(sent0), .current_state(st0)
   );
   uart_tx #(.length(8), .bit_cycles(4)) dut4 (
      .clk(clk), .rstn(rstn), .data_transmit_register(data), .send(send1),
      .ready(rdy1), .data_transmitter(tx1), .shiftout(sh1),
      .data_sent_signal(sent1), .current_state(st1)
   );

   always @(negedge clk) if (sent0) pulses0++;

   typedef struct {
      logic       send;
      logic [7:0] data;
      logic [5:0] exp;
   } vec_t;
   vec_t tbl[11];

   function automatic logic [5:0] obs(input int inst);
      return (inst == 0) ? {rdy0, tx0, sh0, sent0, st0} : {rdy1, tx1, sh1, sent1, st1};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int inst, input logic [5:0] exp);
      logic [5:0] got;
      got = obs(inst);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s dut%0d t=%0t: got {rdy,tx,sh,sent,st}=%b want %b", nm, inst, $time, got, exp);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      compared++;
      if (got != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d want %0d", nm, got, exp);
      end
   endtask

   // Called just after the capture edge; ends just after the DONE edge.
   task automatic check_frame(input int inst, input logic [7:0] w, input int bc, input string nm,
                              input int poke_on, input int poke_off);
      chk({nm, "_load"}, inst, E_LOAD);
      for (int k = 0; k < 8; k++)
         for (int c = 0; c < bc; c++) begin
            step();
            if (k == poke_on && c == 0) begin send0 = 1'b1; data = 8'hFF; end
            if (k == poke_off && c == 0) send0 = 1'b0;
            chk($sformatf("%s_bit%0d", nm, k), inst, {1'b0, w[7-k], 2'b00, 2'b10});
         end
      step();
      chk({nm, "_done"}, inst, E_DONE);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 8'hA5, E_LOAD};
      tbl[1]  = '{1'b0, 8'h00, 6'b010010};
      tbl[2]  = '{1'b0, 8'h00, 6'b000010};
      tbl[3]  = '{1'b0, 8'h00, 6'b010010};
      tbl[4]  = '{1'b0, 8'h00, 6'b000010};
      tbl[5]  = '{1'b0, 8'h00, 6'b000010};
      tbl[6]  = '{1'b0, 8'h00, 6'b010010};
      tbl[7]  = '{1'b0, 8'h00, 6'b000010};
      tbl[8]  = '{1'b0, 8'h00, 6'b010010};
      tbl[9]  = '{1'b0, 8'h00, E_DONE};
      tbl[10] = '{1'b0, 8'h00, E_IDLE};

      #12;
      chk("reset0", 0, E_IDLE);
      chk("reset4", 1, E_IDLE);
      rstn = 1'b1;
      step();
      chk("idle0", 0, E_IDLE);

      // 0xA5 with default timing, table driven
      for (int i = 0; i < 11; i++) begin
         send0 = tbl[i].send;
         data  = tbl[i].data;
         step();
         chk($sformatf("a5_row%0d", i), 0, tbl[i].exp);
      end
      chk_int("a5_pulses", pulses0, 1);

      // bit_cycles=4, 0x3C: done lands at E33
      data = 8'h3C; send1 = 1'b1;
      step();
      send1 = 1'b0; data = 8'h00;
      check_frame(1, 8'h3C, 4, "3c", -1, -1);
      step();
      chk("3c_idle", 1, E_IDLE);

      // 0x81 with an ignored 0xFF request during SHIFT
      data = 8'h81; send0 = 1'b1;
      step();
      send0 = 1'b0; data = 8'h00;
      check_frame(0, 8'h81, 1, "ign", 2, 5);
      step();
      chk("ign_idle", 0, E_IDLE);
      step();
      chk("ign_idle2", 0, E_IDLE);
      chk_int("ign_pulses", pulses0, 2);

      // send held high: 0x81 then 0x7E back to back
      data = 8'h81; send0 = 1'b1;
      step();
      data = 8'h7E;
      check_frame(0, 8'h81, 1, "b2b_a", -1, -1);
      step();
      chk("b2b_idle", 0, E_IDLE);
      step();
      send0 = 1'b0; data = 8'h00;
      check_frame(0, 8'h7E, 1, "b2b_b", -1, -1);
      step();
      chk("b2b_idle2", 0, E_IDLE);
      chk_int("b2b_pulses", pulses0, 4);

      // reset during bit 3 of 0xF0
      data = 8'hF0; send0 = 1'b1;
      step();
      send0 = 1'b0;
      chk("rst_load", 0, E_LOAD);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rst_bit%0d", k), 0, 6'b010010);
      end
      #2 rstn = 1'b0;
      #1 chk("rst_async", 0, E_IDLE);
      step();
      chk("rst_held", 0, E_IDLE);
      #2 rstn = 1'b1;
      step();
      step();
      chk("rst_idle", 0, E_IDLE);
      chk_int("rst_pulses", pulses0, 4);
      data = 8'h0F; send0 = 1'b1;
      step();
      send0 = 1'b0;
      check_frame(0, 8'h0F, 1, "0f", -1, -1);
      step();
      chk("0f_idle", 0, E_IDLE);
      chk_int("0f_pulses", pulses0, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter that pairs with the team's UART receiver. It accepts a parallel word from the controller, frames it with a one-cycle `shiftout` strobe, and shifts it out MSB-first on a single serial line, holding each bit for a programmable number of clocks. It completes with a one-cycle done pulse. It sits between the controller's transmit path and the serial pin or loopback, mirroring the receiver's shift-in / data-ready handshake.

## Interface
- `length`, 8: data word width in bits; must be ≥ 2.
- `bit_cycles`, 1: clocks each bit is held on the line; must be ≥ 1.

- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `data_transmit_register`  in  `length`  word to send; sampled only when a send is accepted.
- `send`  in  1  transmit request; level-sampled each rising edge.
- `ready`  out  1  high when idle and able to accept `send`.
- `data_transmitter`  out  1  serial data line.
- `shiftout`  out  1  frame strobe; high exactly one cycle before the first data bit.
- `data_sent_signal`  out  1  one-cycle pulse after the last bit completes.
- `current_state`  out  2  current FSM state encoding, for debug.

## Operation
- All outputs are registered.
- Reset values: `ready`=1, `data_transmitter`=0, `shiftout`=0, `data_sent_signal`=0, `current_state`=0. Internal shift register and counters reset to 0.
- IDLE (0):
  - `ready`=1; line and strobes low.
  - If `send`=1, capture `data_transmit_register` into the internal shift register, clear counters, and go to LOAD.
- LOAD (1):
  - `ready`=0, `shiftout`=1, line=0. Stay one cycle, then go to SHIFT.
- SHIFT (2):
  - `shiftout`=0; `data_transmitter` = shift register MSB.
  - The bit timer counts 0..`bit_cycles`-1. On the terminal count, shift left by one (0 fills the LSB) and increment the bit counter.
  - When the bit counter reaches `length` (after the final bit's terminal count), go to DONE.
- DONE (3):
  - `data_sent_signal`=1, line=0, `ready`=0. Stay one cycle, then go to IDLE.
- `send` while `ready`=0 is ignored. It is not queued, and the captured word is never altered mid-frame.
- Changes on `data_transmit_register` after capture have no effect.
- `send` held high continuously produces back-to-back frames. A new capture occurs on the first edge where the FSM is in IDLE.
- Counter widths:
  - Bit counter: `$clog2(length+1)`.
  - Bit timer: `max(1, $clog2(bit_cycles))`.
  - No counter wraps within a frame.
- Reset mid-frame: all outputs take reset values immediately (asynchronously). The partial frame is abandoned, no `data_sent_signal` is produced, and the next frame starts clean.

## Timing
- Let E0 be the edge that samples `send`=1 in IDLE.
- After E0: LOAD, `shiftout`=1, `ready`=0.
- After E1: SHIFT; bit k (k=0 is the MSB) is on the line from edge E(1+k·`bit_cycles`) to edge E(1+(k+1)·`bit_cycles`).
- After E(1+`length`·`bit_cycles`): DONE, `data_sent_signal`=1, line=0.
- After E(2+`length`·`bit_cycles`): IDLE, `ready`=1. The earliest next capture is at that same edge +1.
- Frame occupancy is `length`·`bit_cycles`+2 cycles. For defaults this is 10 cycles.

## Structure
- Shared package `uart_pkg` holds:
  - The 2-bit state encodings (IDLE/LOAD/SHIFT/DONE = 0/1/2/3), shared with the receiver's debug decode.
  - Default `length` and `bit_cycles` constants.
- One sub-module, `uart_bit_timer`:
  - Parameter `bit_cycles`; inputs `clk`, `rstn`, `clear`, `enable`; output `tick`.
  - `tick` is high on the terminal count, and the timer then wraps to 0.
  - The shift register, bit counter and FSM stay in `uart_tx`.

## Test plan
- Defaults, `send` pulse with 0xA5:
  - `shiftout` is high one cycle.
  - Line shows 1,0,1,0,0,1,0,1 on consecutive cycles.
  - `data_sent_signal` pulses the next cycle; `ready` returns 10 cycles after the sampling edge.
- `bit_cycles`=4, word 0x3C:
  - Each bit is held exactly 4 cycles: 0,0,1,1,1,1,0,0.
  - `data_sent_signal` occurs at E33.
- 0x81 accepted; then `send` with 0xFF asserted during SHIFT:
  - It is ignored; the line still shows 0x81.
  - Exactly one `data_sent_signal` pulse.
- `send` held high with input switched from 0x81 to 0x7E after the first capture:
  - Two frames, 0x81 then 0x7E, separated by IDLE and LOAD cycles only (0x7E is captured at the first edge where the FSM is in IDLE).
- `rstn` low during bit 3 of 0xF0:
  - Line, `shiftout` and `data_sent_signal` go low immediately; `ready`=1 and state 0.
  - No done pulse; a subsequent 0x0F is sent correctly.
